seq_det_ctrl: RTL and testbench

- Sequencing controller for the serial "101" sequence-detector datapath (Moore, overlapping; detector reset is synchronous active-high; its output is high for one cycle, one clock after the final '1' of each match).
- Accepts parallel words over a valid/ready handshake, clears the detector, and serializes each word into the detector's data input.
- Counts detector output pulses over the word and returns a per-word match count over a second valid/ready handshake.

---
 rtl/seq_det_ctrl.sv | 152 +++++++++++++++
 tb/tb_seq_det_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Sequencing controller for a serial "101" detector: loads a word, clears the detector,
// shifts the word out MSB first and reports the number of matches. SEQ_DET_CTRL_STATS_EN adds tot_match.
module seq_det_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              det_clr,
  output logic              det_din,
  input  logic              det_dout,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_hit,
  output logic              out_valid,
  input  logic              out_ready
`ifdef SEQ_DET_CTRL_STATS_EN
  ,
  output logic [15:0]       tot_match
`endif
);

  // state | meaning
  // IDLE  | waiting for a word, in_ready high
  // CLEAR | one cycle of det_clr so no match carries over from the previous word
  // SHIFT | DATA_W cycles driving det_din, MSB first
  // DRAIN | one idle bit so the detector's response to the last bit is counted
  // DONE  | result presented until out_ready

  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]   bits_left_q, bits_left_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               out_hit_q, out_hit_d;
  logic               in_ready_q, in_ready_d;
  logic               det_clr_q, det_clr_d;
  logic               det_din_q, det_din_d;
  logic               out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    cnt_d       = cnt_q;
    out_cnt_d   = out_cnt_q;
    out_hit_d   = out_hit_q;
    det_din_d   = 1'b0;

    if ((state_q == SHIFT || state_q == DRAIN) && det_dout && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d     = in_data;
          bits_left_d = IDX_W'(DATA_W - 1);
          cnt_d       = '0;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        det_din_d = shift_q[DATA_W-1];
        shift_d   = {shift_q[DATA_W-2:0], 1'b0};
        state_d   = SHIFT;
      end
      SHIFT: begin
        // det_din is registered, so each bit is launched one cycle ahead of its SHIFT cycle
        if (bits_left_q == '0) begin
          state_d = DRAIN;
        end else begin
          det_din_d   = shift_q[DATA_W-1];
          shift_d     = {shift_q[DATA_W-2:0], 1'b0};
          bits_left_d = bits_left_q - IDX_W'(1);
        end
      end
      DRAIN: begin
        out_cnt_d = cnt_d;
        out_hit_d = (cnt_d != '0);
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    det_clr_d   = (state_d == CLEAR);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bits_left_q <= '0;
      cnt_q       <= '0;
      out_cnt_q   <= '0;
      out_hit_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      det_clr_q   <= 1'b1;
      det_din_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      cnt_q       <= cnt_d;
      out_cnt_q   <= out_cnt_d;
      out_hit_q   <= out_hit_d;
      in_ready_q  <= in_ready_d;
      det_clr_q   <= det_clr_d;
      det_din_q   <= det_din_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign det_clr   = det_clr_q;
  assign det_din   = det_din_q;
  assign out_cnt   = out_cnt_q;
  assign out_hit   = out_hit_q;
  assign out_valid = out_valid_q;

`ifdef SEQ_DET_CTRL_STATS_EN
  logic [15:0] tot_q, tot_d;
  logic [16:0] tot_sum;

  always_comb begin
    tot_sum = {1'b0, tot_q} + 17'(out_cnt_q);
    tot_d   = tot_q;
    if (out_valid_q && out_ready)
      tot_d = tot_sum[16] ? 16'hFFFF : tot_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tot_q <= '0;
    else        tot_q <= tot_d;
  end

  assign tot_match = tot_q;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl with a behavioural "101" Moore detector and a scoreboard of
// expected per-word counts; also checks tot_match when SEQ_DET_CTRL_STATS_EN is defined.
module tb_seq_det_ctrl;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              det_clr;
  logic              det_din;
  logic              det_dout;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_hit;
  logic              out_valid;
  logic              out_ready = 1'b1;
`ifdef SEQ_DET_CTRL_STATS_EN
  logic [15:0]       tot_match;
`endif

  seq_det_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .det_clr   (det_clr),
    .det_din   (det_din),
    .det_dout  (det_dout),
    .out_cnt   (out_cnt),
    .out_hit   (out_hit),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SEQ_DET_CTRL_STATS_EN
    ,
    .tot_match (tot_match)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int clr_pulses = 0;
  int clr_snap = 0;
  int accept_cyc = 0;
  int tot_exp = 0;
  int exp_q[$];

  // Moore overlapping "101" detector: 0=idle 1=saw 1 2=saw 10 3=saw 101
  logic [1:0] dst = 2'd0;
  assign det_dout = (dst == 2'd3);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && det_clr) clr_pulses <= clr_pulses + 1;
    if (det_clr) dst <= 2'd0;
    else begin
      case (dst)
        2'd0: dst <= det_din ? 2'd1 : 2'd0;
        2'd1: dst <= det_din ? 2'd1 : 2'd2;
        2'd2: dst <= det_din ? 2'd3 : 2'd0;
        default: dst <= det_din ? 2'd1 : 2'd2;
      endcase
    end
  end

  function automatic int count101(input logic [7:0] w);
    int c = 0;
    for (int i = 7; i >= 2; i--)
      if (w[i] && !w[i-1] && w[i-2]) c++;
    return (c > 15) ? 15 : c;
  endfunction

  task automatic send_word(input logic [7:0] w);
    int guard = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL accept_timeout word=%02h in_ready=%b expected=1", w, in_ready);
      in_valid = 1'b0;
      return;
    end
    clr_snap = clr_pulses;
    @(posedge clk); #1;
    accept_cyc = cyc;
    in_valid   = 1'b0;
    exp_q.push_back(count101(w));
  endtask

  task automatic get_result(input int exp_lat, input int hold);
    int lat = 0;
    int exp_cnt;
    logic [CNT_W-1:0] held;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL result_timeout out_valid=%b expected=1", out_valid);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_lat >= 0) begin
      checks++;
      if (lat !== exp_lat) begin
        failures++;
        $display("FAIL latency got=%0d expected=%0d", lat, exp_lat);
      end
    end
    exp_cnt = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    checks++;
    if (int'(out_cnt) !== exp_cnt) begin
      failures++;
      $display("FAIL out_cnt got=%0d expected=%0d", out_cnt, exp_cnt);
    end
    checks++;
    if (out_hit !== (exp_cnt != 0)) begin
      failures++;
      $display("FAIL out_hit got=%b expected=%b", out_hit, (exp_cnt != 0));
    end
    checks++;
    if (clr_pulses - clr_snap !== 1) begin
      failures++;
      $display("FAIL det_clr_pulses got=%0d expected=1", clr_pulses - clr_snap);
    end
    held = out_cnt;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_cnt !== held || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold cycle=%0d out_valid=%b out_cnt=%0d in_ready=%b expected 1/%0d/0",
                 i, out_valid, out_cnt, in_ready, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL after_handshake out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    tot_exp = tot_exp + ((exp_cnt > 0) ? exp_cnt : 0);
    if (tot_exp > 65535) tot_exp = 65535;
`ifdef SEQ_DET_CTRL_STATS_EN
    checks++;
    if (int'(tot_match) !== tot_exp) begin
      failures++;
      $display("FAIL tot_match got=%0d expected=%0d", tot_match, tot_exp);
    end
`endif
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (out_valid !== 1'b0 || out_cnt !== '0 || out_hit !== 1'b0 || det_din !== 1'b0 ||
        det_clr !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s out_valid=%b out_cnt=%0d out_hit=%b det_din=%b det_clr=%b in_ready=%b expected 0/0/0/0/1/1",
               tag, out_valid, out_cnt, out_hit, det_din, det_clr, in_ready);
    end
`ifdef SEQ_DET_CTRL_STATS_EN
    checks++;
    if (tot_match !== 16'h0) begin
      failures++;
      $display("FAIL %s_tot_match got=%0d expected=0", tag, tot_match);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_values");
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || det_clr !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset in_ready=%b det_clr=%b out_valid=%b expected 1/0/0",
               in_ready, det_clr, out_valid);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_word(8'hAA); get_result(DATA_W + 2, 0);
    send_word(8'h05); get_result(DATA_W + 2, 0);
    send_word(8'h00); get_result(DATA_W + 2, 0);
    send_word(8'hFF); get_result(DATA_W + 2, 0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_word(8'hA8);
    in_data  = 8'h05;
    in_valid = 1'b1;
    get_result(DATA_W + 2, 20);
    send_word(8'h05);
    get_result(DATA_W + 2, 0);
  endtask

  task automatic test_back_to_back();
    int first_acc;
    out_ready = 1'b1;
    send_word(8'hAA);
    first_acc = accept_cyc;
    get_result(DATA_W + 2, 0);
    send_word(8'h01);
    checks++;
    if (accept_cyc - first_acc !== DATA_W + 4) begin
      failures++;
      $display("FAIL word_period got=%0d expected=%0d", accept_cyc - first_acc, DATA_W + 4);
    end
    get_result(DATA_W + 2, 0);
  endtask

  task automatic test_abort();
    int seen = 0;
    out_ready = 1'b1;
    send_word(8'hAA);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("abort_reset");
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    tot_exp = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL aborted_word_out_valid got=%0d cycles expected=0", seen);
    end
    send_word(8'h05);
    get_result(DATA_W + 2, 0);
  endtask

  task automatic test_random();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_word(8'($urandom_range(0, 255)));
      get_result(DATA_W + 2, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
